// File: rtl/chess_board_renderer_if.sv
// Pixel stream from the board renderer into the LCD pixel-write path.
interface chess_board_renderer_if;
  logic        pixelReady;
  logic        pixelWrite;
  logic [15:0] pixelData;
  logic [7:0]  xAddr;
  logic [7:0]  yAddr;
  logic        frameStart;
  logic        frameDone;
  logic        busy;

  modport master (
    input  pixelReady,
    output pixelWrite, pixelData, xAddr, yAddr, frameStart, frameDone, busy
  );

  modport slave (
    output pixelReady,
    input  pixelWrite, pixelData, xAddr, yAddr, frameStart, frameDone, busy
  );
endinterface

// File: rtl/chess_board_renderer.sv
// Chess board renderer: snapshots the 64-square layout bus and streams an
// 8x8 board image as RGB565 pixels in raster order over valid/ready.
module chess_board_renderer #(
  parameter int unsigned SQUARE_PIXELS = 30,
  parameter int unsigned PIECE_INSET   = 8,
  parameter int unsigned BORDER_PIXELS = 3,
  localparam int unsigned CHESS_SQUARES = 64,
  localparam int unsigned SQUARE_WIDTH  = 8,
  localparam int unsigned MATRIX_WIDTH  = CHESS_SQUARES * SQUARE_WIDTH
) (
  input  logic                    clock,
  input  logic                    resetApp,
  input  logic [MATRIX_WIDTH-1:0] Layout,
  input  logic                    refresh,
  chess_board_renderer_if.master  pix
);

  localparam int unsigned SUB_WIDTH    = (SQUARE_PIXELS > 1) ? $clog2(SQUARE_PIXELS) : 1;
  localparam int unsigned FRAME_PIXELS = 8 * SQUARE_PIXELS;

  localparam logic [SUB_WIDTH-1:0] SUB_LAST  = SUB_WIDTH'(SQUARE_PIXELS - 1);
  localparam logic [SUB_WIDTH-1:0] BORDER_LO = SUB_WIDTH'(BORDER_PIXELS);
  localparam logic [SUB_WIDTH-1:0] BORDER_HI = SUB_WIDTH'(SQUARE_PIXELS - BORDER_PIXELS);
  localparam logic [SUB_WIDTH-1:0] INSET_LO  = SUB_WIDTH'(PIECE_INSET);
  localparam logic [SUB_WIDTH-1:0] INSET_HI  = SUB_WIDTH'(SQUARE_PIXELS - PIECE_INSET);
  localparam logic [7:0]           COORD_LAST = 8'(FRAME_PIXELS - 1);

  localparam logic [15:0] LIGHT_COLOUR  = 16'hEF7D;
  localparam logic [15:0] DARK_COLOUR   = 16'h8A22;
  localparam logic [15:0] WHITE_COLOUR  = 16'hFFFF;
  localparam logic [15:0] BLACK_COLOUR  = 16'h0000;
  localparam logic [15:0] CURSOR_COLOUR = 16'hF800;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SNAPSHOT = 2'd1,
    DRAW     = 2'd2,
    DONE     = 2'd3
  } stateType;

  stateType state, stateNext;

  logic                    pending, pendingNext;
  logic [MATRIX_WIDTH-1:0] snapshot, snapshotNext;
  logic [MATRIX_WIDTH-1:0] colourSource;
  logic [SUB_WIDTH-1:0]    subX, subY, subXNext, subYNext;
  logic [2:0]              col, row, colNext, rowNext;
  logic [7:0]              xNext, yNext;
  logic [15:0]             dataNext;
  logic                    writeNext, startNext, doneNext, busyNext;
  logic                    loadPixel, handshake;

  // Colour of one pixel given the square column/screen row and the offset inside the square.
  function automatic logic [15:0] pixelColour(
    input logic [MATRIX_WIDTH-1:0] board,
    input logic [2:0]              colIn,
    input logic [2:0]              rowIn,
    input logic [SUB_WIDTH-1:0]    sx,
    input logic [SUB_WIDTH-1:0]    sy
  );
    logic [2:0] boardY;
    logic [7:0] square;
    logic       cursorHit;
    logic       pieceHit;
    boardY    = 3'd7 - rowIn;
    square    = board[{boardY, colIn, 3'b000} +: 8];
    cursorHit = (square[7:4] == 4'd1) &&
                ((sx < BORDER_LO) || (sy < BORDER_LO) || (sx >= BORDER_HI) || (sy >= BORDER_HI));
    pieceHit  = (square[2:0] != 3'd0) && (square[2:0] != 3'd7) &&
                (sx >= INSET_LO) && (sx < INSET_HI) && (sy >= INSET_LO) && (sy < INSET_HI);
    if (cursorHit) begin
      pixelColour = CURSOR_COLOUR;
    end else if (pieceHit) begin
      pixelColour = square[3] ? BLACK_COLOUR : WHITE_COLOUR;
    end else if (colIn[0] ^ boardY[0]) begin
      pixelColour = LIGHT_COLOUR;
    end else begin
      pixelColour = DARK_COLOUR;
    end
  endfunction

  assign handshake = pix.pixelWrite && pix.pixelReady;

  // State register.
  always_ff @(posedge clock) begin
    if (!resetApp) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Next state, next outputs and raster counters; first pixel colours from the live layout.
  always_comb begin
    stateNext    = state;
    pendingNext  = pending | refresh;
    snapshotNext = snapshot;
    writeNext    = pix.pixelWrite;
    dataNext     = pix.pixelData;
    xNext        = pix.xAddr;
    yNext        = pix.yAddr;
    subXNext     = subX;
    subYNext     = subY;
    colNext      = col;
    rowNext      = row;
    startNext    = 1'b0;
    doneNext     = 1'b0;
    busyNext     = pix.busy;
    loadPixel    = 1'b0;
    colourSource = snapshot;

    case (state)
      IDLE: begin
        if (Layout != snapshot) begin
          pendingNext = 1'b1;
        end
        if (pendingNext) begin
          stateNext = SNAPSHOT;
          busyNext  = 1'b1;
        end
      end

      SNAPSHOT: begin
        stateNext    = DRAW;
        snapshotNext = Layout;
        pendingNext  = refresh;
        colourSource = Layout;
        writeNext    = 1'b1;
        startNext    = 1'b1;
        xNext        = 8'd0;
        yNext        = 8'd0;
        subXNext     = '0;
        subYNext     = '0;
        colNext      = 3'd0;
        rowNext      = 3'd0;
        loadPixel    = 1'b1;
      end

      DRAW: begin
        if (handshake) begin
          if ((pix.xAddr == COORD_LAST) && (pix.yAddr == COORD_LAST)) begin
            stateNext = DONE;
            writeNext = 1'b0;
            busyNext  = 1'b0;
            doneNext  = 1'b1;
          end else begin
            loadPixel = 1'b1;
            if (pix.xAddr == COORD_LAST) begin
              xNext    = 8'd0;
              subXNext = '0;
              colNext  = 3'd0;
              yNext    = pix.yAddr + 8'd1;
              if (subY == SUB_LAST) begin
                subYNext = '0;
                rowNext  = row + 3'd1;
              end else begin
                subYNext = subY + SUB_WIDTH'(1);
              end
            end else begin
              xNext = pix.xAddr + 8'd1;
              if (subX == SUB_LAST) begin
                subXNext = '0;
                colNext  = col + 3'd1;
              end else begin
                subXNext = subX + SUB_WIDTH'(1);
              end
            end
          end
        end
      end

      DONE: begin
        stateNext = IDLE;
      end

      default: begin
        stateNext = IDLE;
      end
    endcase

    if (loadPixel) begin
      dataNext = pixelColour(colourSource, colNext, rowNext, subXNext, subYNext);
    end
  end

  // Registered outputs, snapshot, pending flag and sub-square counters.
  always_ff @(posedge clock) begin
    if (!resetApp) begin
      pending        <= 1'b1;
      snapshot       <= '0;
      pix.pixelWrite <= 1'b0;
      pix.pixelData  <= 16'd0;
      pix.xAddr      <= 8'd0;
      pix.yAddr      <= 8'd0;
      pix.frameStart <= 1'b0;
      pix.frameDone  <= 1'b0;
      pix.busy       <= 1'b0;
      subX           <= '0;
      subY           <= '0;
      col            <= 3'd0;
      row            <= 3'd0;
    end else begin
      pending        <= pendingNext;
      snapshot       <= snapshotNext;
      pix.pixelWrite <= writeNext;
      pix.pixelData  <= dataNext;
      pix.xAddr      <= xNext;
      pix.yAddr      <= yNext;
      pix.frameStart <= startNext;
      pix.frameDone  <= doneNext;
      pix.busy       <= busyNext;
      subX           <= subXNext;
      subY           <= subYNext;
      col            <= colNext;
      row            <= rowNext;
    end
  end

endmodule

// File: tb/tb_chess_board_renderer.sv
// Self-checking bench for chess_board_renderer with a reduced square size.
module tb_chess_board_renderer;

  localparam int SQ     = 10;
  localparam int INSET  = 3;
  localparam int BORDER = 1;
  localparam int SIDE   = 8 * SQ;
  localparam int FRAME  = SIDE * SIDE;

  localparam logic [15:0] LIGHT  = 16'hEF7D;
  localparam logic [15:0] DARK   = 16'h8A22;
  localparam logic [15:0] WHITE  = 16'hFFFF;
  localparam logic [15:0] BLACK  = 16'h0000;
  localparam logic [15:0] CURSOR = 16'hF800;

  logic         clock = 1'b0;
  logic         resetApp;
  logic         refresh;
  logic [511:0] Layout;
  logic [15:0]  frameBuf [0:FRAME-1];

  int checkCount = 0;
  int errorCount = 0;

  chess_board_renderer_if pix ();

  chess_board_renderer #(
    .SQUARE_PIXELS(SQ),
    .PIECE_INSET  (INSET),
    .BORDER_PIXELS(BORDER)
  ) dut (
    .clock   (clock),
    .resetApp(resetApp),
    .Layout  (Layout),
    .refresh (refresh),
    .pix     (pix)
  );

  always #5 clock = ~clock;

  // One comparison: count it and report a mismatch.
  task automatic checkValue(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Reference pixel colour from board coordinates using plain division.
  function automatic logic [15:0] refPixel(input logic [511:0] lay, input int x, input int y);
    int bx, by, sx, sy, idx;
    logic [7:0] sq;
    bit border, inner;
    bx = x / SQ;
    sx = x % SQ;
    by = 7 - (y / SQ);
    sy = y % SQ;
    idx = by * 8 + bx;
    sq = lay[idx*8 +: 8];
    border = (sx < BORDER) || (sy < BORDER) || (sx >= SQ - BORDER) || (sy >= SQ - BORDER);
    inner  = (sx >= INSET) && (sx < SQ - INSET) && (sy >= INSET) && (sy < SQ - INSET);
    if (sq[7:4] == 4'd1 && border) return CURSOR;
    if (sq[2:0] >= 3'd1 && sq[2:0] <= 3'd6 && inner) return sq[3] ? BLACK : WHITE;
    return ((bx + by) % 2 == 0) ? DARK : LIGHT;
  endfunction

  function automatic logic [511:0] randomLayout();
    logic [511:0] lay;
    for (int i = 0; i < 16; i++) lay[i*32 +: 32] = $urandom();
    return lay;
  endfunction

  // Follow one frame from first presentation; eventKind 1 = layout change + refresh, 2 = reset.
  task automatic runFrame(input string tag, input logic [511:0] expLayout, input int stallPct,
                          input int eventAt, input int eventKind, input logic [511:0] eventLayout,
                          output int startLatency);
    int idx, cycles, pixErr, orderErr, stableErr, startErr, doneErr, ex, ey;
    logic prevStall, firstCycle, ready, finished;
    logic [15:0] prevData;
    logic [7:0] prevX, prevY;
    idx = 0; cycles = 0; pixErr = 0; orderErr = 0; stableErr = 0; startErr = 0; doneErr = 0;
    prevStall = 1'b0; firstCycle = 1'b1; finished = 1'b0;
    prevData = 16'd0; prevX = 8'd0; prevY = 8'd0;
    startLatency = 0;
    while (!pix.pixelWrite && startLatency < 50) begin
      @(negedge clock);
      startLatency++;
    end
    checkValue({tag, " start"}, 32'(pix.pixelWrite), 32'd1);
    if (!pix.pixelWrite) return;
    checkValue({tag, " frameStart"}, 32'(pix.frameStart), 32'd1);
    checkValue({tag, " origin"}, {16'd0, pix.xAddr, pix.yAddr}, 32'd0);
    while (!finished && cycles < FRAME * 4) begin
      refresh = 1'b0;
      if (pix.pixelWrite) begin
        ex = idx % SIDE;
        ey = idx / SIDE;
        if (pix.xAddr != 8'(ex) || pix.yAddr != 8'(ey)) orderErr++;
        if (pix.pixelData != refPixel(expLayout, ex, ey)) pixErr++;
        if (idx < FRAME) frameBuf[idx] = pix.pixelData;
        if (prevStall && (pix.pixelData != prevData || pix.xAddr != prevX || pix.yAddr != prevY))
          stableErr++;
        if (pix.frameStart != firstCycle) startErr++;
      end else begin
        orderErr++;
      end
      if (pix.frameDone) doneErr++;
      firstCycle = 1'b0;
      ready = ($urandom_range(99) >= 32'(stallPct));
      pix.pixelReady = ready;
      prevStall = pix.pixelWrite && !ready;
      prevData = pix.pixelData;
      prevX = pix.xAddr;
      prevY = pix.yAddr;
      if (pix.pixelWrite && ready) begin
        idx++;
        if (eventKind == 1 && idx == eventAt) begin
          Layout = eventLayout;
          refresh = 1'b1;
        end
        if (eventKind == 2 && idx == eventAt) resetApp = 1'b0;
      end
      @(negedge clock);
      cycles++;
      if ((eventKind == 2 && !resetApp) || idx == FRAME) finished = 1'b1;
    end
    refresh = 1'b0;
    checkValue({tag, " timeout"}, 32'(finished), 32'd1);
    checkValue({tag, " pixels"}, 32'(pixErr), 32'd0);
    checkValue({tag, " order"}, 32'(orderErr), 32'd0);
    checkValue({tag, " stall stable"}, 32'(stableErr), 32'd0);
    checkValue({tag, " frameStart once"}, 32'(startErr), 32'd0);
    checkValue({tag, " early frameDone"}, 32'(doneErr), 32'd0);
    if (eventKind == 2) begin
      checkValue({tag, " accepted before reset"}, 32'(idx), 32'(eventAt));
      checkValue({tag, " rst pixelWrite"}, 32'(pix.pixelWrite), 32'd0);
      checkValue({tag, " rst data"}, 32'(pix.pixelData), 32'd0);
      checkValue({tag, " rst addr"}, {16'd0, pix.xAddr, pix.yAddr}, 32'd0);
      checkValue({tag, " rst flags"}, {29'd0, pix.frameStart, pix.frameDone, pix.busy}, 32'd0);
    end else begin
      checkValue({tag, " accepted"}, 32'(idx), 32'(FRAME));
      checkValue({tag, " end flags"}, {29'd0, pix.pixelWrite, pix.busy, pix.frameDone}, 32'd1);
    end
  endtask

  // Count any drawing activity over a quiet window.
  task automatic idleCheck(input string tag, input int n);
    int act;
    act = 0;
    repeat (n) begin
      @(negedge clock);
      if (pix.pixelWrite || pix.busy || pix.frameDone) act++;
    end
    checkValue(tag, 32'(act), 32'd0);
  endtask

  function automatic logic [15:0] bufAt(input int x, input int y);
    return frameBuf[y * SIDE + x];
  endfunction

  logic [511:0] oldLayout, newLayout;
  int latency;

  initial begin
    resetApp = 1'b0;
    refresh = 1'b0;
    Layout = '0;
    pix.pixelReady = 1'b0;
    repeat (3) @(negedge clock);
    checkValue("reset pixelWrite", 32'(pix.pixelWrite), 32'd0);
    checkValue("reset pixelData", 32'(pix.pixelData), 32'd0);
    checkValue("reset addr", {16'd0, pix.xAddr, pix.yAddr}, 32'd0);
    checkValue("reset flags", {29'd0, pix.frameStart, pix.frameDone, pix.busy}, 32'd0);

    // Frame after reset release, empty board, always ready.
    resetApp = 1'b1;
    pix.pixelReady = 1'b1;
    @(negedge clock);
    checkValue("snapshot busy", {30'd0, pix.busy, pix.pixelWrite}, 32'd2);
    runFrame("f1", '0, 0, 0, 0, '0, latency);
    checkValue("f1 latency", 32'(latency), 32'd1);
    checkValue("f1 top-left light", 32'(bufAt(0, 0)), 32'(LIGHT));
    checkValue("f1 bottom-left dark", 32'(bufAt(0, SIDE - 1)), 32'(DARK));
    idleCheck("f1 idle after", 30);

    // Cursor + white pawn on square 26, black piece on square 0, random stalls.
    Layout = randomLayout();
    Layout[26*8 +: 8] = 8'h11;
    Layout[0 +: 8] = 8'h0C;
    runFrame("f2", Layout, 30, 0, 0, '0, latency);
    checkValue("f2 cursor corner", 32'(bufAt(2 * SQ, 4 * SQ)), 32'(CURSOR));
    checkValue("f2 white piece", 32'(bufAt(2 * SQ + SQ / 2, 4 * SQ + SQ / 2)), 32'(WHITE));
    checkValue("f2 gap light", 32'(bufAt(2 * SQ + BORDER, 4 * SQ + BORDER)), 32'(LIGHT));
    checkValue("f2 black piece", 32'(bufAt(SQ / 2, 7 * SQ + SQ / 2)), 32'(BLACK));

    // Code 7 is empty: square colour shows through.
    Layout[0 +: 8] = 8'h07;
    runFrame("f3", Layout, 0, 0, 0, '0, latency);
    checkValue("f3 code7 empty", 32'(bufAt(SQ / 2, 7 * SQ + SQ / 2)), 32'(DARK));
    idleCheck("f3 idle after", 10);

    // Layout change plus refresh mid-frame: old frame intact, exactly one redraw.
    oldLayout = randomLayout();
    newLayout = randomLayout();
    Layout = oldLayout;
    runFrame("f4 old", oldLayout, 25, 1500, 1, newLayout, latency);
    runFrame("f5 new", newLayout, 0, 0, 0, '0, latency);
    idleCheck("f5 single redraw", 40);

    // Reset in the middle of a frame, then a complete frame from the origin.
    Layout = randomLayout();
    runFrame("f6 abort", Layout, 20, 1000, 2, '0, latency);
    idleCheck("f6 no frameDone", 2);
    resetApp = 1'b1;
    pix.pixelReady = 1'b1;
    runFrame("f7 restart", Layout, 0, 0, 0, '0, latency);
    idleCheck("f7 idle after", 10);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
